// File: rtl/sd_pkg.sv
// Shared types and helpers for the SD CMD-line responder.
//   CMD_BITS / R2_BITS : frame lengths in bits, start and end bits included
//   rsp_type_e         : response descriptor type
//   state_e            : CMD engine FSM states
//   crc7_next          : one serial step of CRC7 (x^7 + x^3 + 1)
package sd_pkg;

  localparam int CMD_BITS = 48;
  localparam int R2_BITS  = 136;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_R1   = 2'd1,
    RSP_R2   = 2'd2,
    RSP_R3   = 2'd3
  } rsp_type_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_CHECK, S_PRESENT, S_WAIT_RSP, S_NCR, S_TX, S_NCC
  } state_e;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, MSB-first input.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart from zero (wins over en)
//   en, din    : fold din into the CRC on this clock
//   crc        : current remainder
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) crc <= '0;
    else if (en)       crc <= crc7_next(crc, din);
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, hands them to
// user logic, then serialises the R1/R2/R3 response user logic supplies.
//   i_clk, i_rst_n          : SD clock, synchronous active-low reset
//   i_sd_cmd                : CMD pad input (idle high)
//   o_sd_cmd, o_sd_cmd_oe   : CMD pad drive value / enable
//   o_cmd_valid, i_cmd_ready, o_cmd_index, o_cmd_arg : decoded command out
//   o_rsp_ready, i_rsp_valid, i_rsp_type, i_rsp_payload : response descriptor in
//   o_crc_err               : one-cycle pulse on a command CRC7 mismatch
//   o_busy                  : engine not idle
// Build option: define SD_CMD_CRC_CHECK_EN to drop commands with a bad CRC7;
// without it CRC is ignored and o_crc_err stays 0.
module sd_cmd_responder
  import sd_pkg::*;
#(
  parameter int NCR     = 2,
  parameter int NCC_MIN = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_sd_cmd,
  output logic         o_sd_cmd,
  output logic         o_sd_cmd_oe,
  output logic         o_cmd_valid,
  input  logic         i_cmd_ready,
  output logic [5:0]   o_cmd_index,
  output logic [31:0]  o_cmd_arg,
  output logic         o_rsp_ready,
  input  logic         i_rsp_valid,
  input  logic [1:0]   i_rsp_type,
  input  logic [127:0] i_rsp_payload,
  output logic         o_crc_err,
  output logic         o_busy
);

`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_CHK = 1'b1;
`else
  localparam bit CRC_CHK = 1'b0;
`endif

  state_e         state, state_nx;
  logic [7:0]     cnt;        // bit / delay counter, sized for 136-bit frames
  logic [46:0]    rx_sh;      // {tx, idx, arg, crc7, end} after RX
  logic [135:0]   tx_sh;      // response frame, left aligned, shifted out MSB first
  rsp_type_e      tx_type;
  logic [7:0]     tx_last;    // index of the end bit of the response
  logic [6:0]     rx_crc, tx_crc, crc_sh;
  logic [7:0]     crc_lo, crc_off;
  logic           rx_crc_clr, rx_crc_en, tx_crc_en, in_crc, crc_bad;

  // Start bit is sampled in IDLE and contributes nothing to a zero-init CRC,
  // so only the 39 bits following it are folded in.
  sd_crc7 u_rx_crc (.clk(i_clk), .rst_n(i_rst_n), .clr(rx_crc_clr), .en(rx_crc_en),
                    .din(i_sd_cmd), .crc(rx_crc));
  sd_crc7 u_tx_crc (.clk(i_clk), .rst_n(i_rst_n), .clr(state == S_WAIT_RSP), .en(tx_crc_en),
                    .din(tx_sh[135]), .crc(tx_crc));

  assign crc_bad     = (rx_crc != rx_sh[7:1]);
  assign crc_lo      = tx_last - 8'd7;
  assign crc_off     = cnt - crc_lo;
  assign crc_sh      = tx_crc << crc_off[2:0];
  assign in_crc      = (tx_type != RSP_R3) && (cnt >= crc_lo) && (cnt < tx_last);
  assign o_cmd_index = rx_sh[45:40];
  assign o_cmd_arg   = rx_sh[39:8];
  assign o_busy      = (state != S_IDLE);

  always_comb begin
    state_nx    = state;
    o_cmd_valid = 1'b0;
    o_rsp_ready = 1'b0;
    o_crc_err   = 1'b0;
    o_sd_cmd_oe = 1'b0;
    o_sd_cmd    = 1'b1;
    rx_crc_clr  = 1'b0;
    rx_crc_en   = 1'b0;
    tx_crc_en   = 1'b0;
    case (state)
      S_IDLE: begin
        rx_crc_clr = 1'b1;
        if (!i_sd_cmd) state_nx = S_RX;
      end
      S_RX: begin
        rx_crc_en = (cnt < 8'(CMD_BITS - 9));
        if (cnt == 8'(CMD_BITS - 2)) state_nx = S_CHECK;
      end
      S_CHECK: begin
        // Framing errors are dropped silently; CRC errors only when checking is built in.
        if (!rx_sh[46] || !rx_sh[0]) state_nx = S_IDLE;
        else if (CRC_CHK && crc_bad) begin
          o_crc_err = 1'b1;
          state_nx  = S_IDLE;
        end else state_nx = S_PRESENT;
      end
      S_PRESENT: begin
        o_cmd_valid = 1'b1;
        if (i_cmd_ready) state_nx = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        o_rsp_ready = 1'b1;
        if (i_rsp_valid) state_nx = (rsp_type_e'(i_rsp_type) == RSP_NONE) ? S_NCC : S_NCR;
      end
      S_NCR: if (cnt == 8'(NCR - 1)) state_nx = S_TX;
      S_TX: begin
        o_sd_cmd_oe = 1'b1;
        o_sd_cmd    = in_crc ? crc_sh[6] : tx_sh[135];
        case (tx_type)
          RSP_R1:  tx_crc_en = (cnt < 8'(CMD_BITS - 8));
          RSP_R2:  tx_crc_en = (cnt >= 8'd8) && (cnt < 8'(R2_BITS - 8));
          default: tx_crc_en = 1'b0;
        endcase
        if (cnt == tx_last) state_nx = S_NCC;
      end
      S_NCC: if (cnt == 8'(NCC_MIN - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      tx_type <= RSP_NONE;
      tx_last <= '0;
    end else begin
      state <= state_nx;
      // Counter restarts on every state change; terminal counts leave the state, so it never wraps.
      if (state_nx != state) cnt <= '0;
      else if (state inside {S_RX, S_NCR, S_TX, S_NCC}) cnt <= cnt + 8'd1;

      if (state == S_RX) rx_sh <= {rx_sh[45:0], i_sd_cmd};

      if (state == S_WAIT_RSP && i_rsp_valid) begin
        tx_type <= rsp_type_e'(i_rsp_type);
        tx_last <= (rsp_type_e'(i_rsp_type) == RSP_R2) ? 8'(R2_BITS - 1) : 8'(CMD_BITS - 1);
        // CRC field is loaded as all ones; R3 sends it as-is, R1/R2 substitute the live CRC.
        case (rsp_type_e'(i_rsp_type))
          RSP_R2:  tx_sh <= {2'b00, 6'h3F, i_rsp_payload[127:8], 7'h7F, 1'b1};
          RSP_R3:  tx_sh <= {2'b00, 6'h3F, i_rsp_payload[31:0], 7'h7F, 1'b1, 88'd0};
          default: tx_sh <= {2'b00, i_rsp_payload[37:0], 7'h7F, 1'b1, 88'd0};
        endcase
      end else if (state == S_TX) begin
        tx_sh <= {tx_sh[134:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
module tb_sd_cmd_responder;

  localparam int NCR     = 2;
  localparam int NCC_MIN = 8;
`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, sd_in = 1'b1;
  logic         sd_out, sd_oe, cmd_valid, cmd_ready, rsp_ready, rsp_valid, crc_err, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   rsp_type;
  logic [127:0] rsp_payload;

  sd_cmd_responder #(.NCR(NCR), .NCC_MIN(NCC_MIN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sd_cmd(sd_in), .o_sd_cmd(sd_out), .o_sd_cmd_oe(sd_oe),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_index(cmd_index), .o_cmd_arg(cmd_arg),
    .o_rsp_ready(rsp_ready), .i_rsp_valid(rsp_valid), .i_rsp_type(rsp_type),
    .i_rsp_payload(rsp_payload), .o_crc_err(crc_err), .o_busy(busy));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected events keyed by cycle number (value of cyc at a negedge).
  bit           chk_en = 1'b0;
  int           s_cyc = -10, tx_start = -1, tx_end = -1, tx_len = 0;
  bit           m_acc = 1'b0, m_err = 1'b0;
  logic [5:0]   m_idx;
  logic [31:0]  m_arg;
  logic [135:0] tx_frame;
  logic [135:0] cap;
  int           cap_n = 0;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [127:0] v, input int n);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [127:0] h;
    h = {88'd0, 2'b01, idx, arg};
    return {h[39:0], crc7(h, 40), 1'b1};
  endfunction

  // Compare process: pad outputs and handshake outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_oe, e_cmd;
      e_oe  = (cyc >= tx_start) && (cyc < tx_end);
      e_cmd = e_oe ? tx_frame[tx_len - 1 - (cyc - tx_start)] : 1'b1;
      chk("oe", 136'(sd_oe), 136'(e_oe));
      chk("cmd_line", 136'(sd_out), 136'(e_cmd));
      chk("cmd_valid", 136'(cmd_valid), 136'(m_acc && cyc == s_cyc + 1));
      chk("rsp_ready", 136'(rsp_ready), 136'(m_acc && cyc == s_cyc + 2));
      chk("crc_err", 136'(crc_err), 136'(m_err && cyc == s_cyc));
      if (m_acc && cyc == s_cyc + 1) begin
        chk("cmd_index", 136'(cmd_index), 136'(m_idx));
        chk("cmd_arg", 136'(cmd_arg), 136'(m_arg));
      end
      if (sd_oe) begin
        cap = {cap[134:0], sd_out};
        cap_n++;
      end
    end
  end

  task automatic set_rsp(input logic [1:0] t, input logic [127:0] p);
    rsp_type    = t;
    rsp_payload = p;
  endtask

  // Drive one host command and load the model's predictions for it.
  task automatic send_cmd(input logic [47:0] f);
    logic [127:0] h;
    logic ok;
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      if (i == 47) begin
        h     = {88'd0, f[47:8]};
        s_cyc = cyc + 48;
        ok    = f[46] && f[0];
        m_err = ok && CRC_EN && (crc7(h, 40) != f[7:1]);
        m_acc = ok && !m_err;
        m_idx = f[45:40];
        m_arg = f[39:8];
        if (m_acc && rsp_type != 2'd0) begin
          tx_start = s_cyc + 3 + NCR;
          case (rsp_type)
            2'd1: begin h = {88'd0, 2'b00, rsp_payload[37:0]};
                  tx_frame = {88'd0, h[39:0], crc7(h, 40), 1'b1}; tx_len = 48; end
            2'd3: begin tx_frame = {88'd0, 8'h3F, rsp_payload[31:0], 8'hFF}; tx_len = 48; end
            default: begin tx_frame = {8'h3F, rsp_payload[127:8], crc7({8'd0, rsp_payload[127:8]}, 120), 1'b1};
                  tx_len = 136; end
          endcase
          tx_end = tx_start + tx_len;
        end
      end
      sd_in = f[i];
    end
    @(negedge clk);
    sd_in = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] p2;
    cmd_ready = 1'b1;
    rsp_valid = 1'b1;
    set_rsp(2'd0, '0);
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_oe", 136'(sd_oe), 136'(0));
    chk("rst_cmd", 136'(sd_out), 136'(1));
    chk("rst_valid", 136'(cmd_valid), 136'(0));
    chk("rst_rsp_ready", 136'(rsp_ready), 136'(0));
    chk("rst_crc_err", 136'(crc_err), 136'(0));
    chk("rst_busy", 136'(busy), 136'(0));
    chk("rst_index", 136'(cmd_index), 136'(0));
    chk("rst_arg", 136'(cmd_arg), 136'(0));
    // Pin the model's CRC against known SD values
    chk("pin_crc_cmd0", 136'(crc7(128'h40_00000000, 40)), 136'(7'h4A));
    chk("pin_crc_cmd8", 136'(crc7(128'h48_000001AA, 40)), 136'(7'h43));
    chk("pin_crc_r7", 136'(crc7(128'h08_000001AA, 40)), 136'(7'h09));
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0, no response: line never driven
    cap_n = 0;
    send_cmd(48'h40_00000000_95);
    repeat (20) @(negedge clk);
    chk("cmd0_no_drive", 136'(cap_n), 136'(0));
    chk("cmd0_idle", 136'(busy), 136'(0));

    // CMD8 with R1 reply
    set_rsp(2'd1, {90'd0, 6'd8, 32'h000001AA});
    cap_n = 0;
    send_cmd(48'h48_000001AA_87);
    wait_until(tx_end + NCC_MIN + 3);
    chk("r1_bits", 136'(cap_n), 136'(48));
    chk("r1_frame", 136'(cap[47:0]), 136'(48'h08_000001AA_13));
    chk("r1_idle", 136'(busy), 136'(0));

    // CMD0 with a bad CRC byte
    set_rsp(2'd0, '0);
    send_cmd(48'h40_00000000_97);
    repeat (20) @(negedge clk);
    chk("badcrc_idle", 136'(busy), 136'(0));

    // CMD2 with R2 reply; a start bit during NCC must be ignored
    p2 = 128'h123456789ABCDEF0_0FEDCBA987654321;
    set_rsp(2'd2, p2);
    cap_n = 0;
    send_cmd(mk_cmd(6'd2, 32'h0));
    wait_until(tx_end + 1);
    sd_in = 1'b0;
    repeat (2) @(negedge clk);
    sd_in = 1'b1;
    wait_until(tx_end + NCC_MIN + 60);
    chk("r2_bits", 136'(cap_n), 136'(136));
    chk("r2_last_byte", 136'(cap[7:0]), 136'({crc7({8'd0, p2[127:8]}, 120), 1'b1}));
    chk("r2_head", 136'(cap[135:128]), 136'(8'h3F));
    chk("ncc_ignored", 136'(busy), 136'(0));

    // R3: fixed 3F header and 7F trailer, no CRC
    set_rsp(2'd3, {96'd0, 32'h80FF8000});
    cap_n = 0;
    send_cmd(mk_cmd(6'd41, 32'h40300000));
    wait_until(tx_end + NCC_MIN + 3);
    chk("r3_frame", 136'(cap[47:0]), 136'(48'h3F_80FF8000_FF));

    // Framing errors: tx bit 0, then end bit 0
    set_rsp(2'd0, '0);
    send_cmd(48'h00_00000000_95);
    repeat (2) @(negedge clk);
    chk("txbit0_idle", 136'(busy), 136'(0));
    send_cmd(48'h40_00000000_94);
    repeat (2) @(negedge clk);
    chk("endbit0_idle", 136'(busy), 136'(0));
    repeat (4) @(negedge clk);

    // Reset at bit 20 of an R1 response, then a fresh CMD0
    set_rsp(2'd1, {90'd0, 6'd8, 32'h000001AA});
    send_cmd(48'h48_000001AA_87);
    wait_until(tx_start + 20);
    rst_n  = 1'b0;
    tx_end = cyc + 1;
    @(negedge clk);
    chk("rst_mid_oe", 136'(sd_oe), 136'(0));
    chk("rst_mid_cmd", 136'(sd_out), 136'(1));
    @(negedge clk);
    rst_n = 1'b1;
    set_rsp(2'd0, '0);
    send_cmd(48'h40_00000000_95);
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 136'(busy), 136'(0));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
